i2s_multi_receiver: RTL and testbench



---
 rtl/i2s_multi_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_i2s_multi_receiver.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_multi_receiver.sv
// Multi-line I2S capture: NUM_LINES sd lines sharing sck/ws, sign-extended AXI-Stream output via a small FIFO.
// Optional macro I2S_RX_FRAME_CHECK_EN: discard slots shorter than DATA_WIDTH and raise sticky frame_err.
//
// state    | meaning
// ST_SYNC  | waiting for the first ws transition; partial slot discarded
// ST_SHIFT | accumulating bits of the current slot
// ST_PUSH  | writing held words of the closed slot, one line per cycle
module i2s_multi_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_LINES  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 m_axis_aclk,
    input  logic                 m_axis_aresetn,
    input  logic                 sck,
    input  logic                 ws,
    input  logic [NUM_LINES-1:0] sd,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [31:0]          m_axis_tdata,
    output logic [3:0]           m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 37;
    localparam logic [LW-1:0] LAST_IDX = LW'(NUM_LINES - 1);
    localparam logic [AW:0]   DROP_THR = (AW + 1)'(FIFO_DEPTH - NUM_LINES);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {ST_SYNC, ST_SHIFT, ST_PUSH} state_t;

    state_t state, state_nxt;

    logic                  sck_q;
    logic                  ws_prev;
    logic                  bit_event;
    logic                  boundary;
    logic [5:0]            bit_cnt;
    logic [5:0]            cnt_inc;
    logic [DATA_WIDTH-1:0] sr        [NUM_LINES];
    logic [DATA_WIDTH-1:0] sr_next   [NUM_LINES];
    logic [DATA_WIDTH-1:0] hold_data [NUM_LINES];
    logic                  hold_ws;
    logic [LW-1:0]         push_idx;

    logic load_hold;
    logic wr_en;
    logic rd_en;
    logic drop_slot;
    logic no_space;
    logic short_drop;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;

    logic [DATA_WIDTH-1:0] wr_sample;
    logic [31:0]           wr_data;
    logic [3:0]            wr_user;
    logic                  wr_last;

    assign bit_event = sck & ~sck_q;
    assign boundary  = bit_event & (ws != ws_prev);
    assign cnt_inc   = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
    assign no_space  = (count > DROP_THR);

    // Bits land at DATA_WIDTH-1-bit_cnt so a short slot comes out left-justified, zero-filled.
    always_comb begin
        for (int l = 0; l < NUM_LINES; l++) begin
            sr_next[l] = sr[l];
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (6'(DATA_WIDTH - 1 - b) == bit_cnt) begin
                    sr_next[l][b] = sd[l];
                end
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic hold_short;
    logic frame_err_q;
    assign short_drop = hold_short;
    assign frame_err  = frame_err_q;
`else
    assign short_drop = 1'b0;
    assign frame_err  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load_hold = 1'b0;
        wr_en     = 1'b0;
        drop_slot = 1'b0;
        case (state)
            ST_SYNC: begin
                if (boundary) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (boundary) begin
                    load_hold = 1'b1;
                    state_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if ((push_idx == '0) && (short_drop || no_space)) begin
                    drop_slot = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    wr_en = 1'b1;
                    if (push_idx == LAST_IDX) state_nxt = ST_SHIFT;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) state <= ST_SYNC;
        else                 state <= state_nxt;
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            sck_q    <= 1'b0;
            ws_prev  <= 1'b0;
            bit_cnt  <= 6'd0;
            hold_ws  <= 1'b0;
            push_idx <= '0;
            overflow <= 1'b0;
            for (int l = 0; l < NUM_LINES; l++) begin
                sr[l]        <= '0;
                hold_data[l] <= '0;
            end
        end else begin
            sck_q <= sck;
            if (bit_event) begin
                ws_prev <= ws;
                if (boundary) begin
                    bit_cnt <= 6'd0;
                    for (int l = 0; l < NUM_LINES; l++) sr[l] <= '0;
                end else if (state != ST_SYNC) begin
                    bit_cnt <= cnt_inc;
                    sr      <= sr_next;
                end
            end
            if (load_hold) begin
                hold_data <= sr_next;
                hold_ws   <= ws_prev;
            end
            if (state_nxt != ST_PUSH) push_idx <= '0;
            else if (wr_en)           push_idx <= push_idx + LW'(1);
            if (drop_slot && !short_drop) overflow <= 1'b1;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            hold_short  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (load_hold)               hold_short  <= (cnt_inc < 6'(DATA_WIDTH));
            if (drop_slot && short_drop) frame_err_q <= 1'b1;
        end
    end
`endif

    assign wr_sample = hold_data[push_idx];

    generate
        if (DATA_WIDTH < 32) begin : g_sext
            assign wr_data = {{(32 - DATA_WIDTH){wr_sample[DATA_WIDTH-1]}}, wr_sample};
        end else begin : g_full
            assign wr_data = wr_sample;
        end
    endgenerate

    assign wr_user = (hold_ws ? 4'(NUM_LINES) : 4'd0) + 4'(push_idx);
    assign wr_last = hold_ws && (push_idx == LAST_IDX);
    assign wr_word = {wr_last, wr_user, wr_data};

    // Output comes straight from the storage register at rd_ptr; idle outputs read as zero.
    assign m_axis_tvalid = (count != '0);
    assign rd_en         = m_axis_tvalid & m_axis_tready;
    assign rd_word       = mem[rd_ptr];
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? rd_word : '0;

    always_ff @(posedge m_axis_aclk) begin
        if (wr_en && m_axis_aresetn) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && !rd_en)      count <= count + CNT_ONE;
            else if (!wr_en && rd_en) count <= count - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_i2s_multi_receiver.sv
// Scoreboard bench for i2s_multi_receiver: slot-level reference model feeds an expected-word queue,
// a negedge monitor pops and compares every accepted AXI-Stream word.
module tb_i2s_multi_receiver;

    localparam int DW    = 24;
    localparam int NL    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          sck;
    logic          ws;
    logic [NL-1:0] sd;
    logic          tready;
    logic          tvalid;
    logic [31:0]   tdata;
    logic [3:0]    tuser;
    logic          tlast;
    logic          overflow;
    logic          frame_err;

    always #5 clk = ~clk;

    i2s_multi_receiver #(.DATA_WIDTH(DW), .NUM_LINES(NL), .FIFO_DEPTH(DEPTH)) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(aresetn),
        .sck           (sck),
        .ws            (ws),
        .sd            (sd),
        .m_axis_tready (tready),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .overflow      (overflow),
        .frame_err     (frame_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rdy_mode = 0;
    int          lat_T   = -1;
    int          lat_idx = 0;
    bit          lat_arm = 0;
    bit          exp_ovf = 0;
    bit          exp_ferr = 0;
    logic [36:0] exp_q [$];
    logic [31:0] cur_smp [NL];
    bit          stall_prev = 0;
    logic [37:0] stall_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a closed slot yields one word per line, sample left-justified then sign-extended.
    function automatic void model_close(input logic w, input int n);
        logic [31:0] lj;
        logic [31:0] sx;
        logic [3:0]  user;
`ifdef I2S_RX_FRAME_CHECK_EN
        if (n < DW) begin
            exp_ferr = 1'b1;
            return;
        end
`endif
        if (exp_q.size() + NL > DEPTH) begin
            exp_ovf = 1'b1;
            return;
        end
        for (int l = 0; l < NL; l++) begin
            lj = cur_smp[l] << (32 - DW);
            if (n < DW) lj = lj & ~(32'hFFFF_FFFF >> n);
            sx = $signed(lj) >>> (32 - DW);
            user = 4'(w ? NL + l : l);
            exp_q.push_back({(w && l == NL - 1), user, sx});
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        lat_T    = -1;
    endfunction

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tready = 1'b0;
                1:       tready = 1'b1;
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        logic [36:0] e;
        if (aresetn === 1'b1) begin
            if (stall_prev) check("stall_hold", {tvalid, tlast, tuser, tdata}, stall_word);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h/user%0d, expected no word", tdata, tuser);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {tlast, tuser, tdata}, e);
                    if (lat_T >= 0) begin
                        check("latency", 64'(cyc - lat_T), 64'(lat_idx + 2));
                        lat_idx++;
                        if (lat_idx == 2) lat_T = -1;
                    end
                end
            end
            stall_prev = tvalid && !tready;
            stall_word = {tvalid, tlast, tuser, tdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got cycle %0d, expected end before it", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic rand_smp();
        for (int l = 0; l < NL; l++) cur_smp[l] = $urandom;
    endtask

    // Sends an n-bit slot; its last bit goes out with the next slot's ws (one-bit delay).
    task automatic send_slot(input logic w, input int n, input bit emit, input bit rst_after);
        logic [NL-1:0] d;
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < NL; l++) begin
                if (b < DW) d[l] = cur_smp[l][DW-1-b];
                else        d[l] = 1'($urandom_range(0, 1));
            end
            sck = 1'b0;
            ws  = (b == n - 1) ? ~w : w;
            sd  = d;
            repeat (4) @(posedge clk);
            #1;
            sck = 1'b1;
            if (b == n - 1) begin
                if (emit) model_close(w, n);
                if (lat_arm) begin
                    lat_T   = cyc;
                    lat_idx = 0;
                    lat_arm = 0;
                end
            end
            if (b == n - 1 && rst_after) begin
                @(posedge clk);
                #1;
                aresetn = 1'b0;
                model_reset();
                @(posedge clk);
                @(negedge clk);
                check("rst_tvalid", tvalid, 0);
                check("rst_ovf", overflow, 0);
                check("rst_ferr", frame_err, 0);
                aresetn = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
            end else begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(posedge clk);
            i++;
        end
        check(name, 64'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        sck     = 1'b0;
        ws      = 1'b0;
        sd      = '0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", tvalid, 0);
        check("reset_tdata", tdata, 0);
        check("reset_tuser", tuser, 0);
        check("reset_tlast", tlast, 0);
        check("reset_ovf", overflow, 0);
        check("reset_ferr", frame_err, 0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("post_reset_tvalid", tvalid, 0);
        @(posedge clk);
        #1;

        // Partial left slot before the first ws edge is discarded, then a full right slot.
        rdy_mode = 1;
        rand_smp();
        send_slot(1'b0, 10, 1'b0, 1'b0);
        rand_smp();
        send_slot(1'b1, 32, 1'b1, 1'b0);
        wait_drain("drain_first");

        cur_smp[0] = 32'h0012_3456;
        cur_smp[1] = 32'h007F_FFFF;
        lat_arm = 1'b1;
        send_slot(1'b0, 32, 1'b1, 1'b0);
        cur_smp[0] = 32'h00AB_CDEF;
        cur_smp[1] = 32'h0080_0000;
        send_slot(1'b1, 32, 1'b1, 1'b0);
        wait_drain("drain_normal");

        rdy_mode = 2;
        repeat (6) begin
            rand_smp();
            send_slot(1'b0, $urandom_range(DW, 32), 1'b1, 1'b0);
            rand_smp();
            send_slot(1'b1, $urandom_range(DW, 32), 1'b1, 1'b0);
        end
        rdy_mode = 1;
        wait_drain("drain_random");
        check("random_ovf", overflow, exp_ovf);
        check("random_ferr", frame_err, exp_ferr);

        rdy_mode = 0;
        repeat (4) begin
            rand_smp();
            send_slot(1'b0, 32, 1'b1, 1'b0);
            rand_smp();
            send_slot(1'b1, 32, 1'b1, 1'b0);
        end
        @(negedge clk);
        check("bp_ovf", overflow, exp_ovf);
        check("bp_expected_words", 64'(exp_q.size()), DEPTH);
        check("bp_tvalid", tvalid, 1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain("drain_bp");
        @(negedge clk);
        check("bp_empty_tvalid", tvalid, 0);
        @(posedge clk);
        #1;

        cur_smp[0] = 32'h00A5_A500 | ($urandom & 32'hFF);
        cur_smp[1] = $urandom;
        send_slot(1'b0, 16, 1'b1, 1'b0);
        rand_smp();
        send_slot(1'b1, 32, 1'b1, 1'b0);
        wait_drain("drain_short");
        check("short_ferr", frame_err, exp_ferr);
        check("short_ovf", overflow, exp_ovf);

        rand_smp();
        send_slot(1'b0, 32, 1'b1, 1'b0);
        wait_drain("drain_pre_rst");
        rand_smp();
        send_slot(1'b1, 32, 1'b1, 1'b1);

        rand_smp();
        send_slot(1'b0, 8, 1'b0, 1'b0);
        rand_smp();
        send_slot(1'b1, 32, 1'b1, 1'b0);
        rand_smp();
        send_slot(1'b0, 32, 1'b1, 1'b0);
        rand_smp();
        send_slot(1'b1, 32, 1'b1, 1'b0);
        wait_drain("drain_after_rst");
        @(negedge clk);
        check("final_ovf", overflow, exp_ovf);
        check("final_ferr", frame_err, exp_ferr);
        check("final_tvalid", tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
